// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU: instruction width, opcodes and the
// instr_capture FSM state encoding.
package mini_cpu_pkg;

    localparam int unsigned INSTR_W = 18;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_ADDI  = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_SUBI  = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;

    typedef enum logic [2:0] {
        CAP_OFF      = 3'd0,
        CAP_IDLE     = 3'd1,
        CAP_DB_PRESS = 3'd2,
        CAP_ISSUE    = 3'd3,
        CAP_WAIT_REL = 3'd4,
        CAP_DB_REL   = 3'd5
    } cap_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser for a raw push-button plus a stable-sample counter
// that qualifies the level requested by the owning FSM.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic qual_en,
    input  logic qual_lvl,
    input  logic restart,
    output logic btn_c,
    output logic stable_c
);

    localparam int unsigned CLOG_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned CNT_W  = (CLOG_W > 20) ? CLOG_W : 20;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchroniser resets to the released level so btn starts inactive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    assign btn_c = sync_q[1] ^ ACTIVE_LOW;

    // Any state change or disagreeing sample restarts the stability window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart || !qual_en || (btn_c != qual_lvl)) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stable_c = qual_en && (btn_c == qual_lvl) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/instr_capture.sv
// Debounced one-shot instruction capture in front of the control unit.
// Optional issued-instruction counter enabled by INSTR_CAPTURE_COUNT_EN.
module instr_capture #(
    parameter int unsigned INSTR_W         = mini_cpu_pkg::INSTR_W,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] sw,
    input  logic               ligar,
    input  logic               enviar,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               busy,
    output logic               ligado,
    output logic [7:0]         instr_count
);
    import mini_cpu_pkg::*;

    cap_state_e   state_q, state_d;
    logic [1:0]   ligar_sync_q;
    logic         btn_c, stable_c, qual_en_c, qual_lvl_c, restart_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ligar_sync_q <= 2'b00;
        end else begin
            ligar_sync_q <= {ligar_sync_q[0], ligar};
        end
    end

    assign ligado = ligar_sync_q[1];

    assign qual_en_c  = (state_q == CAP_DB_PRESS) || (state_q == CAP_DB_REL);
    assign qual_lvl_c = (state_q == CAP_DB_PRESS);
    assign restart_c  = (state_d != state_q);

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_enviar_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (enviar),
        .qual_en  (qual_en_c),
        .qual_lvl (qual_lvl_c),
        .restart  (restart_c),
        .btn_c    (btn_c),
        .stable_c (stable_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CAP_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Power loss overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            CAP_OFF:      if (ligado) state_d = CAP_IDLE;
            CAP_IDLE:     if (btn_c) state_d = CAP_DB_PRESS;
            CAP_DB_PRESS: begin
                if (!btn_c)        state_d = CAP_IDLE;
                else if (stable_c) state_d = CAP_ISSUE;
            end
            CAP_ISSUE:    state_d = CAP_WAIT_REL;
            CAP_WAIT_REL: if (!btn_c) state_d = CAP_DB_REL;
            CAP_DB_REL: begin
                if (btn_c)         state_d = CAP_WAIT_REL;
                else if (stable_c) state_d = CAP_IDLE;
            end
            default:      state_d = CAP_OFF;
        endcase
        if (!ligado) state_d = CAP_OFF;
    end

    // Outputs registered from next state so instr and instr_valid land together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            instr_valid <= (state_d == CAP_ISSUE);
            busy        <= (state_d != CAP_OFF) && (state_d != CAP_IDLE);
            if (state_d == CAP_ISSUE) begin
                instr <= sw;
            end else if (state_d == CAP_OFF) begin
                instr <= '0;
            end
        end
    end

`ifdef INSTR_CAPTURE_COUNT_EN
    logic [7:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else if (state_d == CAP_ISSUE) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = 8'd0;
`endif

endmodule
